aes_sub_bytes_scheduler: RTL and testbench
==========================================

Name: aes_sub_bytes_scheduler

Overview:
- Time-shares one external, combinational 32-bit S-box slice between two requesters.
- Requester 1 is the round datapath: full 128-bit SubBytes / InvSubBytes.
- Requester 2 is key expansion: 32-bit SubWord, always forward S-box.
- Block jobs are processed one 32-bit word per cycle over 4 cycles; key jobs take 1 cycle.
- Arbitration is per job; a started job is never preempted.

Parameters:
- KEY_PRIORITY, 0: 0 = round-robin between requesters; 1 = key requester always wins ties.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous reset, active-high.
- Block_valid  in  1  block job request.
- Block_ready  out  1  block job accepted when Block_valid && Block_ready at rising Clk.
- Block_encrypt  in  1  1 = S-box, 0 = inverse S-box; sampled at accept.
- Block_in  in  `AES_BLOCK_SIZE  block to substitute; sampled at accept.
- Block_out_valid  out  1  result available.
- Block_out_ready  in  1  result consumed when Block_out_valid && Block_out_ready.
- Block_out  out  `AES_BLOCK_SIZE  substituted block.
- Key_valid  in  1  key word request.
- Key_ready  out  1  key word accepted.
- Key_word  in  32  word to SubWord; sampled at accept.
- Key_out_valid  out  1  result available.
- Key_out_ready  in  1  result consumed.
- Key_out  out  32  SubWord result.
- Slice_encrypt  out  1  select for shared slice.
- Slice_input  out  32  shared slice input.
- Slice_output  in  32  shared slice output; combinational, same cycle.

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; internal registers 0; last_grant = KEY. Any in-flight job is discarded; no partial result ever appears.
- FSM states: IDLE, BLOCK, KEY, BLOCK_OUT, KEY_OUT.
- IDLE:
  - Block_ready = 1 iff block wins arbitration; Key_ready = 1 iff key wins. Ready depends on the other requester's valid, never on its own.
  - A single requester valid always wins.
  - Tie, KEY_PRIORITY=0: the requester not equal to last_grant wins. The first tie after reset therefore goes to block.
  - Tie, KEY_PRIORITY=1: key wins.
  - On grant: last_grant is updated; inputs are latched. Block grant goes to BLOCK with cnt=0; key grant goes to KEY.
- BLOCK:
  - Slice_encrypt = latched encrypt; Slice_input = latched block bits [32*cnt +: 32], word 0 = bits [31:0].
  - At each edge, Slice_output is written into result bits [32*cnt +: 32] and cnt increments.
  - After the cnt=3 edge, go to BLOCK_OUT.
  - Both readies are 0.
- KEY: Slice_encrypt = 1; Slice_input = latched word. At the edge, Slice_output is written to Key_out; go to KEY_OUT.
- BLOCK_OUT / KEY_OUT:
  - Respective out_valid = 1; data is held stable until the ready handshake, then return to IDLE.
  - No new job is accepted in the same cycle as the handshake.
  - Both input readies are 0.
- IDLE output values on the slice interface: Slice_encrypt = 0, Slice_input = 0.
- Latency: block accept edge to Block_out_valid high = 4 cycles; key = 1 cycle.
- Throughput: one job at a time.
- Back-to-back rate: block job every 6 cycles with Block_out_ready tied high; key job every 3 cycles.
- Block_out / Key_out retain their last value after the handshake; they are meaningful only while valid.
- Valid inputs dropping before acceptance is permitted; no request is latched.

Test Plan:
- Encrypt, all zeros: Block_in=128'h0, Block_encrypt=1, Block_out_ready=1 → Block_out=128'h6363…63, valid exactly 4 cycles after accept, Slice_input steps through words 0..3.
- Key word: Key_word=32'h53535353 → Key_out=32'hEDEDEDED, Slice_encrypt=1, valid 1 cycle after accept.
- Decrypt, per-word distinct values: Block_in={32'hEDEDEDED, 32'h63636363, 32'hEDEDEDED, 32'h63636363}, Block_encrypt=0 → Block_out={32'h53535353, 32'h00000000, 32'h53535353, 32'h00000000}, proving word order.
- Round-robin, KEY_PRIORITY=0: both valid continuously from reset → grants alternate block, key, block, key.
- Key priority, KEY_PRIORITY=1: both valid continuously → key granted on every tie.
- Backpressure: Block_out_ready held low 10 cycles → Block_out_valid and Block_out stable; Block_ready and Key_ready stay 0 despite Key_valid=1.
- Reset mid-job: Rst asserted at cnt=2 → all outputs 0 immediately. After release, an all-zero encrypt job is accepted and returns all 0x63, with no stale data and no stray valid.

Source files
------------

// File: rtl/aes_sub_bytes_scheduler_if.sv
// aes_sub_bytes_scheduler_if: block/key request and result handshakes plus the shared S-box slice.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
interface aes_sub_bytes_scheduler_if;
    logic                       block_valid;
    logic                       block_ready;
    logic                       block_encrypt;
    logic [`AES_BLOCK_SIZE-1:0] block_in;
    logic                       block_out_valid;
    logic                       block_out_ready;
    logic [`AES_BLOCK_SIZE-1:0] block_out;
    logic                       key_valid;
    logic                       key_ready;
    logic [31:0]                key_word;
    logic                       key_out_valid;
    logic                       key_out_ready;
    logic [31:0]                key_out;
    logic                       slice_encrypt;
    logic [31:0]                slice_input;
    logic [31:0]                slice_output;
    modport master (
        output block_valid, block_encrypt, block_in, block_out_ready,
        output key_valid, key_word, key_out_ready, slice_output,
        input  block_ready, block_out_valid, block_out,
        input  key_ready, key_out_valid, key_out, slice_encrypt, slice_input
    );
    modport slave (
        input  block_valid, block_encrypt, block_in, block_out_ready,
        input  key_valid, key_word, key_out_ready, slice_output,
        output block_ready, block_out_valid, block_out,
        output key_ready, key_out_valid, key_out, slice_encrypt, slice_input
    );
endinterface

// File: rtl/aes_sub_bytes_scheduler.sv
// aes_sub_bytes_scheduler: time-shares one 32-bit S-box slice between block SubBytes and key SubWord jobs.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
module aes_sub_bytes_scheduler #(
    parameter bit KEY_PRIORITY = 1'b0
) (
    input logic clk,
    input logic rst,
    aes_sub_bytes_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BLOCK, KEY, BLOCK_OUT, KEY_OUT} state_t;
    state_t                     state, state_n;
    logic [1:0]                 cnt;
    logic                       last_key;
    logic                       enc;
    logic [`AES_BLOCK_SIZE-1:0] blk;
    logic [`AES_BLOCK_SIZE-1:0] res;
    logic [31:0]                kw;
    logic [31:0]                kres;
    logic                       idle, block_rdy, key_rdy, block_acc, key_acc;
    // Each ready looks only at the other side's valid; ties resolve by last grant or key priority.
    always_comb begin
        idle      = state == IDLE && !rst;
        block_rdy = idle && (!bus.key_valid || (!KEY_PRIORITY && last_key));
        key_rdy   = idle && (!bus.block_valid || KEY_PRIORITY || !last_key);
        block_acc = bus.block_valid && block_rdy;
        key_acc   = bus.key_valid && key_rdy;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = block_acc ? BLOCK : key_acc ? KEY : IDLE;
            BLOCK:     state_n = cnt == 2'd3 ? BLOCK_OUT : BLOCK;
            KEY:       state_n = KEY_OUT;
            BLOCK_OUT: state_n = bus.block_out_ready ? IDLE : BLOCK_OUT;
            KEY_OUT:   state_n = bus.key_out_ready ? IDLE : KEY_OUT;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            last_key <= 1'b1;
            enc      <= 1'b0;
            blk      <= '0;
            res      <= '0;
            kw       <= '0;
            kres     <= '0;
        end else begin
            state <= state_n;
            if (block_acc) begin
                last_key <= 1'b0;
                enc      <= bus.block_encrypt;
                blk      <= bus.block_in;
                cnt      <= 2'd0;
            end
            if (key_acc) begin
                last_key <= 1'b1;
                kw       <= bus.key_word;
            end
            if (state == BLOCK) begin
                res[32*cnt +: 32] <= bus.slice_output;
                cnt               <= cnt + 2'd1;
            end
            if (state == KEY) kres <= bus.slice_output;
        end
    end
    assign bus.block_ready     = block_rdy;
    assign bus.key_ready       = key_rdy;
    assign bus.block_out_valid = state == BLOCK_OUT;
    assign bus.key_out_valid   = state == KEY_OUT;
    assign bus.block_out       = res;
    assign bus.key_out         = kres;
    assign bus.slice_encrypt   = state == BLOCK ? enc : state == KEY;
    assign bus.slice_input     = state == BLOCK ? blk[32*cnt +: 32] : state == KEY ? kw : 32'd0;
endmodule

// File: tb/tb_aes_sub_bytes_scheduler.sv
// tb_aes_sub_bytes_scheduler: job-level model of the scheduler checked every cycle, plus directed literal cases.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
module tb_aes_sub_bytes_scheduler;
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    aes_sub_bytes_scheduler_if b0();
    aes_sub_bytes_scheduler_if b1();
    aes_sub_bytes_scheduler #(.KEY_PRIORITY(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    aes_sub_bytes_scheduler #(.KEY_PRIORITY(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x, input logic e);
        sb = 8'h00;
        if (e) sb = SBOX[x];
        else for (int i = 0; i < 256; i++) if (SBOX[i] == x) sb = i[7:0];
    endfunction
    function automatic logic [31:0] sw(input logic [31:0] w, input logic e);
        for (int i = 0; i < 4; i++) sw[8*i +: 8] = sb(w[8*i +: 8], e);
    endfunction
    function automatic logic [127:0] sblk(input logic [127:0] d, input logic e);
        for (int i = 0; i < 16; i++) sblk[8*i +: 8] = sb(d[8*i +: 8], e);
    endfunction

    // External combinational S-box slices
    assign b0.slice_output = sw(b0.slice_input, b0.slice_encrypt);
    assign b1.slice_output = sw(b1.slice_input, b1.slice_encrypt);

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    // Job model: one outstanding job, known phase since acceptance, per-cycle expectations.
    int           cyc = 0;
    int           acc = 0;
    int           ph;
    logic         busy = 1'b0;
    logic         jb = 1'b0;
    logic         lk = 1'b1;
    logic         men = 1'b0;
    logic [127:0] din = '0;
    logic [31:0]  kin = '0;
    logic         ebr, ekr, ebv, ekv;
    logic         grants [$];

    always begin
        @(negedge clk);
        #3;
        cyc++;
        if (rst) begin
            chk("rst_ctrl", {b0.block_ready, b0.key_ready, b0.block_out_valid, b0.key_out_valid, b0.slice_encrypt}, 0);
            chk("rst_block_out", b0.block_out, 0);
            chk("rst_key_out", b0.key_out, 0);
            chk("rst_slice_input", b0.slice_input, 0);
            busy = 1'b0;
            lk   = 1'b1;
        end else begin
            ph  = cyc - acc;
            ebv = busy && jb && ph >= 5;
            ekv = busy && !jb && ph >= 2;
            ebr = !busy && (!b0.key_valid || lk);
            ekr = !busy && (!b0.block_valid || !lk);
            chk("block_ready", b0.block_ready, ebr);
            chk("key_ready", b0.key_ready, ekr);
            chk("block_out_valid", b0.block_out_valid, ebv);
            chk("key_out_valid", b0.key_out_valid, ekv);
            if (ebv) chk("block_out", b0.block_out, sblk(din, men));
            if (ekv) chk("key_out", b0.key_out, sw(kin, 1'b1));
            if (busy && jb && ph >= 1 && ph <= 4) begin
                chk("slice_input_block", b0.slice_input, din[32*(ph-1) +: 32]);
                chk("slice_encrypt_block", b0.slice_encrypt, men);
            end
            if (busy && !jb && ph == 1) begin
                chk("slice_input_key", b0.slice_input, kin);
                chk("slice_encrypt_key", b0.slice_encrypt, 1'b1);
            end
            if (!busy) chk("slice_idle", {b0.slice_encrypt, b0.slice_input}, 0);
            if ((ebv && b0.block_out_ready) || (ekv && b0.key_out_ready)) busy = 1'b0;
            else if (b0.block_valid && ebr) begin
                busy = 1'b1; jb = 1'b1; acc = cyc; din = b0.block_in; men = b0.block_encrypt; lk = 1'b0;
                grants.push_back(1'b0);
            end else if (b0.key_valid && ekr) begin
                busy = 1'b1; jb = 1'b0; acc = cyc; kin = b0.key_word; lk = 1'b1;
                grants.push_back(1'b1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_block(input logic e, input logic [127:0] d);
        b0.block_encrypt = e;
        b0.block_in      = d;
        b0.block_valid   = 1'b1;
        #1;
        for (int i = 0; i < 20 && !b0.block_ready; i++) begin @(negedge clk); #2; end
        chk("block_accept", b0.block_ready, 1'b1);
        step();
        b0.block_valid = 1'b0;
    endtask

    task automatic wait_block(output int lat);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            if (b0.block_out_valid) begin lat = j; break; end
            step();
        end
    endtask

    task automatic run_block(input logic e, input logic [127:0] d, output logic [127:0] r, output int lat);
        start_block(e, d);
        wait_block(lat);
        r = b0.block_out;
        step();
    endtask

    task automatic run_key(input logic [31:0] w, output logic [31:0] r, output int lat);
        b0.key_word  = w;
        b0.key_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !b0.key_ready; i++) begin @(negedge clk); #2; end
        chk("key_accept", b0.key_ready, 1'b1);
        step();
        b0.key_valid = 1'b0;
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            if (b0.key_out_valid) begin lat = j; break; end
            step();
        end
        r = b0.key_out;
        step();
    endtask

    logic [127:0] r;
    logic [31:0]  kr;
    int           lat;
    int           nk;

    initial begin
        {b0.block_valid, b0.block_encrypt, b0.key_valid} = 3'b000;
        {b1.block_valid, b1.block_encrypt, b1.key_valid} = 3'b000;
        b0.block_in = '0; b0.key_word = '0; b1.block_in = '0; b1.key_word = '0;
        {b0.block_out_ready, b0.key_out_ready, b1.block_out_ready, b1.key_out_ready} = 4'b1111;
        // Round-robin with both requesters valid straight out of reset
        b0.block_valid = 1'b1; b0.block_encrypt = 1'b1; b0.key_valid = 1'b1; b0.key_word = 32'h53535353;
        #22 rst = 1'b0;
        repeat (17) step();
        b0.block_valid = 1'b0; b0.key_valid = 1'b0;
        repeat (3) step();
        chk("rr_grant_count", grants.size(), 4);
        if (grants.size() >= 4) chk("rr_grant_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
        run_block(1'b1, 128'h0, r, lat);
        chk("enc_zero_out", r, {16{8'h63}});
        chk("enc_zero_latency", lat, 4);
        run_key(32'h53535353, kr, lat);
        chk("key_word_out", kr, 32'hEDEDEDED);
        chk("key_latency", lat, 1);
        run_block(1'b0, {32'hEDEDEDED, 32'h63636363, 32'hEDEDEDED, 32'h63636363}, r, lat);
        chk("dec_word_order", r, {32'h53535353, 32'h00000000, 32'h53535353, 32'h00000000});
        // Backpressure on the block result while a key request waits
        b0.block_out_ready = 1'b0;
        start_block(1'b1, {32'h53535353, 32'h00000000, 32'h53535353, 32'h00000000});
        b0.key_word = 32'h00000000; b0.key_valid = 1'b1;
        wait_block(lat);
        chk("bp_latency", lat, 4);
        r = b0.block_out;
        chk("bp_data", r, {32'hEDEDEDED, 32'h63636363, 32'hEDEDEDED, 32'h63636363});
        repeat (10) begin
            step();
            chk("bp_valid_held", b0.block_out_valid, 1'b1);
            chk("bp_data_held", b0.block_out, r);
            chk("bp_readies", {b0.block_ready, b0.key_ready}, 2'b00);
        end
        b0.block_out_ready = 1'b1;
        repeat (5) step();
        b0.key_valid = 1'b0;
        repeat (4) step();
        // Asynchronous reset in the middle of a block job (cnt = 2)
        start_block(1'b1, 128'h0);
        step(); step();
        #1 rst = 1'b1;
        #1;
        chk("rstmid_ctrl", {b0.block_ready, b0.key_ready, b0.block_out_valid, b0.key_out_valid, b0.slice_encrypt}, 0);
        chk("rstmid_block_out", b0.block_out, 0);
        chk("rstmid_slice_input", b0.slice_input, 0);
        step();
        #1 rst = 1'b0;
        step();
        run_block(1'b1, 128'h0, r, lat);
        chk("rstmid_after_out", r, {16{8'h63}});
        chk("rstmid_after_latency", lat, 4);
        // Key priority instance: key wins every tie
        b1.block_valid = 1'b1; b1.block_encrypt = 1'b1; b1.key_valid = 1'b1;
        nk = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("kp_block_ready", b1.block_ready, 1'b0);
            if (b1.key_ready) nk++;
            step();
        end
        b1.block_valid = 1'b0; b1.key_valid = 1'b0;
        chk("kp_key_grants", nk, 4);
        chk("kp_key_out", b1.key_out, 32'h63636363);
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
